// File: rtl/atm_input_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_input_pkg                                                 |
// | Brief    : Shared types and constants for the ATM operator-input path.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package atm_input_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        DONE = 2'd2
    } entry_state_t;

    localparam int BTN_U    = 0;
    localparam int BTN_D    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int BTN_C    = 4;
    localparam int NUM_BTNS = 5;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : button_debounce                                               |
// | Brief    : 2-flop synchronizer, stability counter and rising-edge pulse. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int c_COUNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_COUNT_WIDTH-1:0] c_COUNT_LAST = c_COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                     r_sync0;
    logic                     r_sync1;
    logic                     r_level;
    logic                     r_level_d;
    logic                     r_press;
    logic [c_COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sync0 <= raw;
            r_sync1 <= r_sync0;
            // Any sample agreeing with the current level restarts the count.
            if (r_sync1 != r_level) begin
                if (r_count == c_COUNT_LAST) begin
                    r_level <= r_sync1;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_count <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_entry                                                  |
// | Brief    : Debounced 5-button editor producing a committed 4-digit BCD.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module keypad_entry
    import atm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        BTNC,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic        editing,
    output logic [15:0] code,
    output logic        entry_valid
);

    localparam logic [1:0] c_CURSOR_MSD = 2'd3;
    localparam logic [1:0] c_CURSOR_LSD = 2'd0;

    logic [NUM_BTNS-1:0] w_raw;
    logic [NUM_BTNS-1:0] w_press;
    logic [NUM_BTNS-1:0] w_level_unused;

    assign w_raw[BTN_U] = BTNU;
    assign w_raw[BTN_D] = BTND;
    assign w_raw[BTN_L] = BTNL;
    assign w_raw[BTN_R] = BTNR;
    assign w_raw[BTN_C] = BTNC;

    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .raw  (w_raw[i]),
                .level(w_level_unused[i]),
                .press(w_press[i])
            );
        end
    endgenerate

    entry_state_t r_state;
    entry_state_t w_state_next;
    logic [15:0]  r_digits;
    logic [15:0]  w_digits_next;
    logic [1:0]   r_cursor;
    logic [1:0]   w_cursor_next;
    logic [15:0]  r_code;
    logic [15:0]  w_code_next;
    logic         r_valid;
    logic         w_valid_next;
    logic [3:0]   w_nibble;

    assign w_nibble = r_digits[{r_cursor, 2'b00} +: 4];

    always_comb begin
        w_state_next  = r_state;
        w_digits_next = r_digits;
        w_cursor_next = r_cursor;
        w_code_next   = r_code;
        w_valid_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_digits_next = '0;
                w_cursor_next = c_CURSOR_MSD;
                if (enable) begin
                    w_state_next = EDIT;
                end
            end
            EDIT: begin
                // Losing enable aborts the session before any press is considered.
                if (!enable) begin
                    w_state_next  = IDLE;
                    w_digits_next = '0;
                    w_cursor_next = c_CURSOR_MSD;
                end else if (w_press[BTN_C]) begin
                    w_code_next  = r_digits;
                    w_valid_next = 1'b1;
                    w_state_next = DONE;
                end else if (w_press[BTN_U]) begin
                    w_digits_next[{r_cursor, 2'b00} +: 4] = bcd_inc(w_nibble);
                end else if (w_press[BTN_D]) begin
                    w_digits_next[{r_cursor, 2'b00} +: 4] = bcd_dec(w_nibble);
                end else if (w_press[BTN_L]) begin
                    if (r_cursor != c_CURSOR_MSD) begin
                        w_cursor_next = r_cursor + 2'd1;
                    end
                end else if (w_press[BTN_R]) begin
                    if (r_cursor != c_CURSOR_LSD) begin
                        w_cursor_next = r_cursor - 2'd1;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    w_state_next  = IDLE;
                    w_digits_next = '0;
                    w_cursor_next = c_CURSOR_MSD;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_digits_next = '0;
                w_cursor_next = c_CURSOR_MSD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_digits <= '0;
            r_cursor <= c_CURSOR_MSD;
            r_code   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_digits <= w_digits_next;
            r_cursor <= w_cursor_next;
            r_code   <= w_code_next;
            r_valid  <= w_valid_next;
        end
    end

    assign digits      = r_digits;
    assign cursor      = r_cursor;
    assign editing     = (r_state == EDIT);
    assign code        = r_code;
    assign entry_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_entry                                               |
// | Brief    : Directed and randomized checks of keypad_entry against a      |
// |            behavioural model of the entry rules. Revision : 1.0          |
// +--------------------------------------------------------------------------+
module tb_keypad_entry;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  btn = 5'b0;   // bit 0..4 = U, D, L, R, C
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic        editing;
    logic [15:0] code;
    logic        entry_valid;

    int checks = 0;
    int errors = 0;
    int dut_strobes = 0;

    always #5 clk = ~clk;

    keypad_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .BTNU       (btn[0]),
        .BTND       (btn[1]),
        .BTNL       (btn[2]),
        .BTNR       (btn[3]),
        .BTNC       (btn[4]),
        .digits     (digits),
        .cursor     (cursor),
        .editing    (editing),
        .code       (code),
        .entry_valid(entry_valid)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples reach the debouncer two edges late, a level
    // flips once the last DB seen samples all disagree with it, and a rise acts
    // on the FSM two edges after the level changes.
    bit raw_h [5][2];
    bit win   [5][DB];
    bit lvl_h [5][3];
    bit m_lvl [5];
    bit pr    [5];
    int md    [4];
    int mcur;
    int mstate;          // 0 idle, 1 edit, 2 done
    logic [15:0] mcode;
    bit mvalid;

    function automatic logic [15:0] mpack();
        return {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 5; b++) begin
                raw_h[b][0] = 0; raw_h[b][1] = 0; m_lvl[b] = 0;
                for (int k = 0; k < 3; k++) lvl_h[b][k] = 0;
                for (int k = 0; k < DB; k++) win[b][k] = 0;
            end
            for (int k = 0; k < 4; k++) md[k] = 0;
            mcur = 3; mstate = 0; mcode = 16'h0; mvalid = 0;
        end else begin
            for (int b = 0; b < 5; b++) pr[b] = lvl_h[b][1] && !lvl_h[b][2];
            mvalid = 0;
            if (mstate == 0) begin
                if (enable) mstate = 1;
            end else if (!enable) begin
                mstate = 0; mcur = 3;
                for (int k = 0; k < 4; k++) md[k] = 0;
            end else if (mstate == 1) begin
                if (pr[4]) begin
                    mcode = mpack(); mvalid = 1; mstate = 2;
                end else if (pr[0]) md[mcur] = (md[mcur] + 1) % 10;
                else if (pr[1]) md[mcur] = (md[mcur] + 9) % 10;
                else if (pr[2]) mcur = (mcur == 3) ? 3 : mcur + 1;
                else if (pr[3]) mcur = (mcur == 0) ? 0 : mcur - 1;
            end
            for (int b = 0; b < 5; b++) begin
                bit all_diff;
                for (int k = DB - 1; k > 0; k--) win[b][k] = win[b][k-1];
                win[b][0] = raw_h[b][1];
                all_diff = 1;
                for (int k = 0; k < DB; k++) if (win[b][k] == m_lvl[b]) all_diff = 0;
                if (all_diff) m_lvl[b] = !m_lvl[b];
                lvl_h[b][2] = lvl_h[b][1]; lvl_h[b][1] = lvl_h[b][0]; lvl_h[b][0] = m_lvl[b];
                raw_h[b][1] = raw_h[b][0]; raw_h[b][0] = btn[b];
            end
        end
        #1;
        chk("digits",      digits,             mpack());
        chk("cursor",      16'(cursor),        16'(mcur));
        chk("editing",     16'(editing),       16'(mstate == 1));
        chk("code",        code,               mcode);
        chk("entry_valid", 16'(entry_valid),   16'(mvalid));
        if (entry_valid === 1'b1) dut_strobes++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [4:0] mask);
        btn = mask;
        cyc(8);
        btn = 5'b0;
        cyc(8);
    endtask

    task automatic new_session();
        enable = 1'b0; cyc(2);
        enable = 1'b1; cyc(2);
    endtask

    initial begin
        cyc(3);
        chk("reset_digits", digits, 16'h0000);
        chk("reset_cursor", 16'(cursor), 16'd3);
        chk("reset_code",   code,   16'h0000);
        chk("reset_valid",  16'(entry_valid), 16'd0);
        chk("reset_edit",   16'(editing), 16'd0);
        rst = 1'b0;
        cyc(2);

        // Basic edit
        enable = 1'b1; cyc(2);
        chk("idle_to_edit", 16'(editing), 16'd1);
        repeat (3) tap(5'b00001);
        tap(5'b01000);
        tap(5'b00010);
        chk("basic_digits", digits, 16'h3900);
        chk("basic_cursor", 16'(cursor), 16'd2);
        tap(5'b10000);
        chk("basic_code",    code, 16'h3900);
        chk("basic_strobes", 16'(dut_strobes), 16'd1);
        chk("basic_editing", 16'(editing), 16'd0);
        tap(5'b00001);
        chk("done_ignores", digits, 16'h3900);

        // Wrap and saturate
        new_session();
        tap(5'b00010);
        chk("wrap_down", digits, 16'h9000);
        tap(5'b00001);
        chk("wrap_up", digits, 16'h0000);
        tap(5'b00100);
        chk("sat_left", 16'(cursor), 16'd3);
        repeat (4) tap(5'b01000);
        chk("sat_right", 16'(cursor), 16'd0);

        // Bounce rejection then one clean press
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            cyc(2);
        end
        btn = 5'b0; cyc(8);
        chk("bounce_reject", digits, 16'h0000);
        btn[0] = 1'b1; cyc(6);
        btn = 5'b0; cyc(10);
        chk("clean_press", digits, 16'h0001);

        // Build 1234 then press C and U together
        repeat (3) tap(5'b00001);
        tap(5'b00100); repeat (3) tap(5'b00001);
        tap(5'b00100); repeat (2) tap(5'b00001);
        tap(5'b00100); tap(5'b00001);
        chk("build_1234", digits, 16'h1234);
        tap(5'b10001);
        chk("simul_code",    code,   16'h1234);
        chk("simul_digits",  digits, 16'h1234);
        chk("simul_strobes", 16'(dut_strobes), 16'd2);

        // Abort: enable drops on the cycle the C press is acted on
        new_session();
        tap(5'b01000);
        repeat (5) tap(5'b00001);
        chk("abort_setup", digits, 16'h0500);
        btn = 5'b10000;
        cyc(7);
        enable = 1'b0;
        cyc(3);
        btn = 5'b0; cyc(8);
        chk("abort_strobes", 16'(dut_strobes), 16'd2);
        chk("abort_digits",  digits, 16'h0000);
        chk("abort_cursor",  16'(cursor), 16'd3);
        chk("abort_idle",    16'(editing), 16'd0);
        chk("abort_code",    code, 16'h1234);

        // Reset while in DONE
        enable = 1'b1; cyc(2);
        tap(5'b10000);
        chk("done_strobes", 16'(dut_strobes), 16'd3);
        rst = 1'b1; cyc(1);
        chk("rst_done_code",   code, 16'h0000);
        chk("rst_done_cursor", 16'(cursor), 16'd3);
        chk("rst_done_edit",   16'(editing), 16'd0);

        // Button held through reset produces exactly one move after release
        btn = 5'b01000; cyc(3);
        rst = 1'b0; cyc(20);
        btn = 5'b0; cyc(10);
        chk("hold_rst_cursor", 16'(cursor), 16'd2);

        // Randomized phase
        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 3) == 0) btn = 5'($urandom);
            else if ($urandom_range(0, 5) == 0) btn = 5'b0;
            else btn = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 60) == 0) rst = 1'b1;
            cyc($urandom_range(1, 12));
            rst = 1'b0;
        end
        btn = 5'b0; cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
